// File: rtl/banked_register_file.sv
// Dual-bank (integer x / floating-point f) register file: three combinational read ports,
// one write port, optional write-to-read bypass and a per-register pending-write scoreboard.
module banked_register_file #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rs3_addr,
    input  logic            rs1_fp,
    input  logic            rs2_fp,
    input  logic            rs3_fp,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] rd3,
    output logic            busy1,
    output logic            busy2,
    output logic            busy3,

    input  logic            wr_en,
    input  logic            wr_fp,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,

    input  logic            iss_en,
    input  logic            iss_fp,
    input  logic [AW-1:0]   iss_addr
);

    // Bank index 0 = x bank, 1 = f bank.
    logic [XLEN-1:0]  mem_q  [2][NREGS];
    logic [XLEN-1:0]  mem_d  [2][NREGS];
    logic [NREGS-1:0] pend_q [2];
    logic [NREGS-1:0] pend_d [2];

    logic wr_ok;
    logic iss_ok;

    // x0 is hardwired: writes and issues targeting it never touch state.
    assign wr_ok  = wr_en  && (wr_fp  || (wr_addr  != '0));
    assign iss_ok = iss_en && (iss_fp || (iss_addr != '0));

    // Set is applied after clear so a same-cycle issue keeps ownership with the new op.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[wr_fp][wr_addr]  = wr_data;
            pend_d[wr_fp][wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[iss_fp][iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                pend_q[b] <= '0;
                for (int unsigned r = 0; r < NREGS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    logic [AW-1:0]   ra   [3];
    logic            rfp  [3];
    logic [XLEN-1:0] rdat [3];
    logic            rbsy [3];

    assign ra[0]  = rs1_addr;
    assign ra[1]  = rs2_addr;
    assign ra[2]  = rs3_addr;
    assign rfp[0] = rs1_fp;
    assign rfp[1] = rs2_fp;
    assign rfp[2] = rs3_fp;

    // Bypass is gated by rst_n so reads stay at zero while reset is held.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            rdat[p] = '0;
            rbsy[p] = 1'b0;
            if (rfp[p] || (ra[p] != '0)) begin
                if (BYPASS && rst_n && wr_en && (wr_fp == rfp[p]) && (wr_addr == ra[p])) begin
                    rdat[p] = wr_data;
                end else begin
                    rdat[p] = mem_q[rfp[p]][ra[p]];
                    rbsy[p] = pend_q[rfp[p]][ra[p]];
                end
            end
        end
    end

    assign rd1   = rdat[0];
    assign rd2   = rdat[1];
    assign rd3   = rdat[2];
    assign busy1 = rbsy[0];
    assign busy2 = rbsy[1];
    assign busy3 = rbsy[2];

endmodule
